drive_cmd_scheduler: RTL and testbench

Command scheduler between the robot command sources and the `uart_comm` transmitter. It arbitrates a manual (keyboard/WASD) source against an autonomous source and clamps speed. It enforces a per-source watchdog that forces STOP. It sequences `uart_comm` transfers over a valid/ready handshake, sending on every change of the selected command and re-sending periodically so the robot link stays alive.

---
 rtl/drive_pkg.sv | 51 +++++
 rtl/drive_cmd_scheduler_if.sv | 12 +
 rtl/drive_cmd_scheduler_ms_tick_gen.sv | 31 +++
 rtl/drive_cmd_scheduler.sv | 160 ++++++++++++++++
 tb/tb_drive_cmd_scheduler.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/drive_pkg.sv
// Shared types for the drive command path: move encodings, source ids, scheduler states
// and the command sanitiser applied before arbitration.
package drive_pkg;

    localparam int CMD_W   = 4;
    localparam int SPEED_W = 4;

    typedef enum logic [3:0] {
        FWD      = 4'b0000,
        FWD_L    = 4'b0001,
        FWD_R    = 4'b0010,
        BACK     = 4'b0011,
        SPIN_CCW = 4'b0100,
        SPIN_CW  = 4'b0101,
        BACK_L   = 4'b0110,
        BACK_R   = 4'b0111,
        STOP     = 4'b1000
    } move_cmd_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        MAN  = 2'd1,
        AUTO = 2'd2
    } src_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [CMD_W-1:0]   cmd;
        logic [SPEED_W-1:0] speed;
    } drive_word_t;

    // Codes above STOP are not moves; they collapse to STOP, and STOP never carries speed.
    function automatic drive_word_t sanitize(input logic [CMD_W-1:0] cmd,
                                             input logic [SPEED_W-1:0] speed,
                                             input logic [SPEED_W-1:0] max_speed);
        drive_word_t w;
        if (cmd >= STOP) begin
            w.cmd   = STOP;
            w.speed = 4'd0;
        end else begin
            w.cmd   = cmd;
            w.speed = (speed > max_speed) ? max_speed : speed;
        end
        return w;
    endfunction

endpackage

// File: rtl/drive_cmd_scheduler_if.sv
// valid/ready transfer bus from the scheduler (master) to the uart_comm transmitter (slave).
interface drive_cmd_scheduler_if;
    import drive_pkg::*;

    logic [CMD_W-1:0]   tx_cmd;
    logic [SPEED_W-1:0] tx_speed;
    logic               tx_valid;
    logic               tx_ready;

    modport master (output tx_cmd, output tx_speed, output tx_valid, input tx_ready);
    modport slave  (input tx_cmd, input tx_speed, input tx_valid, output tx_ready);
endinterface

// File: rtl/drive_cmd_scheduler_ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_HZ/1000-1 and emits a registered 1-cycle tick.
module ms_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int TC = CLK_HZ / 1000;
    localparam int CW = $clog2(TC);
    localparam logic [CW-1:0] TERM = CW'(TC - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Prescaler counter and terminal-count pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == TERM) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/drive_cmd_scheduler.sv
// Arbitrates manual vs autonomous drive commands, enforces a per-source watchdog and
// sequences change-driven plus periodic keep-alive transfers to uart_comm.
module drive_cmd_scheduler
    import drive_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int RESEND_MS   = 100,
    parameter int WATCHDOG_MS = 500,
    parameter int MAX_SPEED   = 9
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [3:0]            man_cmd,
    input  logic [3:0]            man_speed,
    input  logic                  man_valid,
    input  logic                  auto_en,
    input  logic [3:0]            auto_cmd,
    input  logic [3:0]            auto_speed,
    input  logic                  auto_valid,
    drive_cmd_scheduler_if.master tx,
    output logic [1:0]            active_src,
    output logic                  wd_stop
);
    localparam int AGE_W = $clog2(WATCHDOG_MS + 1);
    localparam int RS_W  = $clog2(RESEND_MS + 1);
    localparam logic [AGE_W-1:0]   AGE_MAX   = AGE_W'(WATCHDOG_MS);
    localparam logic [RS_W-1:0]    RS_MAX    = RS_W'(RESEND_MS);
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);
    localparam drive_word_t STOP_WORD  = '{cmd: STOP, speed: 4'd0};
    localparam drive_word_t NEVER_SENT = '{cmd: 4'b1111, speed: 4'b1111};

    logic             tick_s;
    drive_word_t      man_r, auto_r, man_w_s, auto_w_s, sel_s, tx_word_r, last_r;
    logic [AGE_W-1:0] man_age_r, auto_age_r;
    logic             man_loaded_r, auto_loaded_r, man_live_s, auto_live_s;
    src_t             sel_src_s, active_src_r;
    sched_state_t     state_r, state_next_s;
    logic             load_tx_s, accept_s, tx_valid_r, wd_stop_r;
    logic [RS_W-1:0]  resend_r;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (.clk(CLOCK_50), .rst(reset), .tick(tick_s));

    // Source slots: a strobe reloads and restarts the age, which wins over a same-cycle tick
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            man_r         <= STOP_WORD;
            auto_r        <= STOP_WORD;
            man_age_r     <= AGE_MAX;
            auto_age_r    <= AGE_MAX;
            man_loaded_r  <= 1'b0;
            auto_loaded_r <= 1'b0;
        end else begin
            if (man_valid) begin
                man_r        <= '{cmd: man_cmd, speed: man_speed};
                man_age_r    <= '0;
                man_loaded_r <= 1'b1;
            end else if (tick_s && (man_age_r != AGE_MAX)) begin
                man_age_r <= man_age_r + AGE_W'(1);
            end
            if (auto_valid) begin
                auto_r        <= '{cmd: auto_cmd, speed: auto_speed};
                auto_age_r    <= '0;
                auto_loaded_r <= 1'b1;
            end else if (tick_s && (auto_age_r != AGE_MAX)) begin
                auto_age_r <= auto_age_r + AGE_W'(1);
            end
        end
    end

    // Liveness and priority: moving manual > live auto > manual STOP > forced STOP
    always_comb begin
        man_w_s     = sanitize(man_r.cmd, man_r.speed, SPEED_MAX);
        auto_w_s    = sanitize(auto_r.cmd, auto_r.speed, SPEED_MAX);
        man_live_s  = (man_age_r < AGE_MAX);
        auto_live_s = auto_en && (auto_age_r < AGE_MAX);
        sel_s       = STOP_WORD;
        sel_src_s   = NONE;
        if (man_live_s && (man_w_s.cmd != STOP)) begin
            sel_s     = man_w_s;
            sel_src_s = MAN;
        end else if (auto_live_s) begin
            sel_s     = auto_w_s;
            sel_src_s = AUTO;
        end else if (man_live_s) begin
            sel_s     = man_w_s;
            sel_src_s = MAN;
        end else begin
            sel_s     = STOP_WORD;
            sel_src_s = NONE;
        end
    end

    // Scheduler state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: send on change or keep-alive expiry, hold in SEND until accepted
    always_comb begin
        state_next_s = state_r;
        load_tx_s    = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if ((sel_s != last_r) || (resend_r == RS_MAX)) begin
                    state_next_s = SEND;
                    load_tx_s    = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (tx.tx_ready) begin
                    state_next_s = IDLE;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Transfer datapath, keep-alive timer and status outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tx_word_r    <= STOP_WORD;
            tx_valid_r   <= 1'b0;
            last_r       <= NEVER_SENT;
            resend_r     <= '0;
            active_src_r <= NONE;
            wd_stop_r    <= 1'b0;
        end else begin
            active_src_r <= sel_src_s;
            wd_stop_r    <= !man_live_s && !auto_live_s && (man_loaded_r || auto_loaded_r);
            if (load_tx_s) begin
                tx_word_r  <= sel_s;
                tx_valid_r <= 1'b1;
            end else if (accept_s) begin
                tx_valid_r <= 1'b0;
                last_r     <= tx_word_r;
            end
            if (accept_s) begin
                resend_r <= '0;
            end else if ((state_r == IDLE) && tick_s && (resend_r != RS_MAX)) begin
                resend_r <= resend_r + RS_W'(1);
            end
        end
    end

    assign tx.tx_cmd   = tx_word_r.cmd;
    assign tx.tx_speed = tx_word_r.speed;
    assign tx.tx_valid = tx_valid_r;
    assign active_src  = active_src_r;
    assign wd_stop     = wd_stop_r;
endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Directed bench for drive_cmd_scheduler with a 10-cycle ms tick, 5 ms resend, 20 ms watchdog.
module tb_drive_cmd_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] man_cmd, man_speed, auto_cmd, auto_speed;
    logic       man_valid, auto_en, auto_valid, wd_stop;
    logic [1:0] active_src;
    int         checks = 0;
    int         errors = 0;
    int         n;
    logic       stable;

    always #5 clk = ~clk;

    drive_cmd_scheduler_if tx_if ();

    drive_cmd_scheduler #(
        .CLK_HZ(10_000), .RESEND_MS(5), .WATCHDOG_MS(20), .MAX_SPEED(9)
    ) dut (
        .CLOCK_50(clk), .reset(reset),
        .man_cmd(man_cmd), .man_speed(man_speed), .man_valid(man_valid),
        .auto_en(auto_en), .auto_cmd(auto_cmd), .auto_speed(auto_speed), .auto_valid(auto_valid),
        .tx(tx_if), .active_src(active_src), .wd_stop(wd_stop)
    );

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx(input int budget, output int cycles);
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (tx_if.tx_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_stop(input int budget, output int cycles);
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if ((tx_if.tx_valid === 1'b1) && (tx_if.tx_cmd === 4'b1000)) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic strobe_man(input logic [3:0] c, input logic [3:0] s);
        man_cmd   = c;
        man_speed = s;
        man_valid = 1'b1;
        step(1);
        man_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tx_if.tx_ready = 1'b1;
        man_cmd = 4'd0; man_speed = 4'd0; man_valid = 1'b0;
        auto_en = 1'b0; auto_cmd = 4'd0; auto_speed = 4'd0; auto_valid = 1'b0;
        step(3);
        chk("rst_valid", tx_if.tx_valid, 1'b0);
        chk("rst_cmd", tx_if.tx_cmd, 4'b1000);
        chk("rst_speed", tx_if.tx_speed, 4'd0);
        chk("rst_src", active_src, 2'd0);
        chk("rst_wd", wd_stop, 1'b0);

        // Post-reset STOP, then keep-alive spacing
        reset = 1'b0;
        wait_tx(2, n);
        chk("boot_seen", (n >= 1), 1'b1);
        chk("boot_word", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h80);
        chk("boot_wd", wd_stop, 1'b0);
        step(1);
        wait_tx(60, n);
        chk("resend_gap", (n >= 42 && n <= 51), 1'b1);
        chk("resend_word", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h80);
        step(1);

        // Manual strobe: idle one cycle, then valid with the new word
        strobe_man(4'b0000, 4'd5);
        chk("man_lat_idle", tx_if.tx_valid, 1'b0);
        step(1);
        chk("man_lat_valid", tx_if.tx_valid, 1'b1);
        chk("man_word", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h05);
        chk("man_src", active_src, 2'd1);
        step(1);

        // Simultaneous auto move and manual STOP: auto wins
        auto_en = 1'b1; auto_cmd = 4'b0100; auto_speed = 4'd3; auto_valid = 1'b1;
        strobe_man(4'b1000, 4'd0);
        auto_valid = 1'b0;
        wait_tx(3, n);
        chk("auto_seen", (n >= 1), 1'b1);
        chk("auto_word", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h43);
        chk("auto_src", active_src, 2'd2);
        step(1);
        strobe_man(4'b0101, 4'd2);
        wait_tx(3, n);
        chk("preempt_word", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h52);
        chk("preempt_src", active_src, 2'd1);
        step(1);

        // Watchdog: manual goes silent for 20 ticks
        auto_en = 1'b0;
        strobe_man(4'b0000, 4'd5);
        wait_stop(260, n);
        chk("wd_delay", (n >= 192 && n <= 204), 1'b1);
        chk("wd_speed", tx_if.tx_speed, 4'd0);
        chk("wd_stop_hi", wd_stop, 1'b1);
        chk("wd_src", active_src, 2'd0);
        step(1);
        strobe_man(4'b0011, 4'd6);
        wait_tx(3, n);
        chk("wd_clear_word", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h36);
        chk("wd_stop_lo", wd_stop, 1'b0);
        step(1);

        // Speed clamp and invalid code
        strobe_man(4'b0001, 4'd15);
        wait_tx(3, n);
        chk("clamp_word", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h19);
        step(1);
        strobe_man(4'b1010, 4'd7);
        wait_tx(3, n);
        chk("invalid_seen", (n >= 1), 1'b1);
        chk("invalid_word", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h80);
        chk("invalid_src", active_src, 2'd1);
        step(1);

        // Back-pressure: word in flight stays put while a newer one arrives
        tx_if.tx_ready = 1'b0;
        strobe_man(4'b0000, 4'd4);
        wait_tx(3, n);
        chk("stall_first", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h04);
        strobe_man(4'b0011, 4'd6);
        stable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if ((tx_if.tx_valid !== 1'b1) || ({tx_if.tx_cmd, tx_if.tx_speed} !== 8'h04)) stable = 1'b0;
            step(1);
        end
        chk("stall_stable", stable, 1'b1);
        tx_if.tx_ready = 1'b1;
        step(1);
        tx_if.tx_ready = 1'b0;
        chk("gap_idle", tx_if.tx_valid, 1'b0);
        step(1);
        chk("latest_valid", tx_if.tx_valid, 1'b1);
        chk("latest_word", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h36);
        step(3);
        reset = 1'b1;
        #2;
        chk("async_drop", tx_if.tx_valid, 1'b0);
        chk("async_cmd", tx_if.tx_cmd, 4'b1000);
        chk("async_src", active_src, 2'd0);
        step(2);
        tx_if.tx_ready = 1'b1;
        reset = 1'b0;
        wait_tx(2, n);
        chk("rerun_seen", (n >= 1), 1'b1);
        chk("rerun_word", {tx_if.tx_cmd, tx_if.tx_speed}, 8'h80);
        chk("rerun_wd", wd_stop, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
